// File: rtl/mips_cpu_fetch.sv
// Purpose : MIPS instruction fetch/sequencer; alternates FETCH and EXEC, with a one-slot branch delay.
// Latency : one instruction per two cycles with a zero-wait memory; each wait state adds one cycle.
// Backpr. : instr_waitrequest holds the fetch address; stall holds the executing instr/pc.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   instr_address/read            instruction memory request (address = pc)
//   instr_waitrequest/readdata    memory response
//   instr, instr_valid, pc        executing instruction, its address, execute strobe
//   link_addr                     pc + 8 (return address for jal/jalr/bal)
//   stall                         datapath hold request
//   branch, branch_cond, jump,
//   jump_reg, rs_data             redirect requests and operands from control/ALU
//   active                        low once the CPU has halted on a jump to address 0
module mips_cpu_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] instr_address,
  output logic        instr_read,
  input  logic        instr_waitrequest,
  input  logic [31:0] instr_readdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        branch_cond,
  input  logic        jump_reg,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        active
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_nxt;
  // Low only during the first cycle out of reset, so no read is presented while rst_n is low
  // and the first request appears on the first rising edge after release.
  logic        started;
  logic        pending;
  logic [31:0] pending_target;

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        taken;
  logic        fetch_done;
  logic        exec_done;

  assign pc_plus4  = pc + 32'd4;
  assign link_addr = pc + 32'd8;
  assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

  // jump_reg beats jump beats branch; rs_data is taken as-is, alignment is not checked.
  assign taken  = jump_reg | jump | (branch & branch_cond);
  assign target = jump_reg ? rs_data :
                  jump     ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                             pc_plus4 + br_offset;

  // A recorded redirect always applies after the delay slot, never before it.
  assign next_pc = pending ? pending_target : pc_plus4;

  assign fetch_done = (state == FETCH) && started && !instr_waitrequest;
  assign exec_done  = (state == EXEC) && !stall;

  assign instr_address = pc;
  assign instr_read    = (state == FETCH) && started;
  assign instr_valid   = (state == EXEC);
  assign active        = (state != HALTED);

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (fetch_done) state_nxt = EXEC;
      EXEC:    if (!stall) state_nxt = (next_pc == 32'h0) ? HALTED : FETCH;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FETCH;
      started        <= 1'b0;
      pc             <= RESET_VECTOR;
      instr          <= 32'h0;
      pending        <= 1'b0;
      pending_target <= 32'h0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      if (fetch_done) instr <= instr_readdata;
      if (exec_done) begin
        pc <= next_pc;
        if (pending) begin
          // Delay slot finishing: any branch/jump it contains is dropped.
          pending <= 1'b0;
        end else if (taken) begin
          pending        <= 1'b1;
          pending_target <= target;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_fetch.sv
module tb_mips_cpu_fetch;

  localparam logic [31:0] V    = 32'hBFC00000;
  localparam logic [31:0] A1   = 32'h24010001;
  localparam logic [31:0] A2   = 32'h24020002;
  localparam logic [31:0] A3   = 32'h24030003;
  localparam logic [31:0] A4   = 32'h24040004;
  localparam logic [31:0] A5   = 32'h24050005;
  localparam logic [31:0] JR   = 32'h03E00008; // jr $31
  localparam logic [31:0] BEQ  = 32'h1022FFFF; // beq $1,$2,-1
  localparam logic [31:0] BNE  = 32'h14220010; // bne $1,$2,+16
  localparam logic [31:0] JAL  = 32'h0FF00040; // jal -> BFC00100
  localparam logic [31:0] JMP  = 32'h0BF00080; // j   -> BFC00200

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_address;
  logic        instr_read;
  logic        instr_waitrequest = 1'b0;
  logic [31:0] instr_readdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        branch_cond = 1'b0;
  logic        jump_reg = 1'b0;
  logic [31:0] rs_data = 32'h0;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        active;

  mips_cpu_fetch #(.RESET_VECTOR(V)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_address(instr_address), .instr_read(instr_read),
    .instr_waitrequest(instr_waitrequest), .instr_readdata(instr_readdata),
    .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .branch(branch), .jump(jump), .branch_cond(branch_cond),
    .jump_reg(jump_reg), .rs_data(rs_data),
    .pc(pc), .link_addr(link_addr), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    int          cycles;
  } exp_t;

  exp_t        eq[$];
  logic [31:0] fq[$];
  logic [31:0] mem [logic [31:0]];

  int vectors = 0;
  int miscompares = 0;

  // Stimulus knobs, consumed by the driver.
  logic [31:0] wait_addr = 32'h0;
  int          wait_left = 0;
  logic [31:0] stall_pc = 32'h0;
  int          stall_left = 0;
  int          br_taken_left = 0;
  logic [31:0] rs_val = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic push_f(input logic [31:0] a);
    fq.push_back(a);
  endtask

  task automatic push_e(input logic [31:0] a, input logic [31:0] ins, input int cyc);
    exp_t e;
    e.pc = a; e.ins = ins; e.cycles = cyc;
    eq.push_back(e);
  endtask

  // Driver: memory, control decoder and stall source, updated 1 time unit after each edge.
  initial begin
    logic       drv_prev_valid;
    logic [5:0] op;
    drv_prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      instr_readdata = mem_rd(instr_address);
      if (instr_read && instr_address == wait_addr && wait_left > 0) begin
        instr_waitrequest = 1'b1;
        wait_left--;
      end else begin
        instr_waitrequest = 1'b0;
      end
      op       = instr[31:26];
      branch   = (op == 6'd4) || (op == 6'd5);
      jump     = (op == 6'd2) || (op == 6'd3);
      jump_reg = (op == 6'd0) && (instr[5:0] == 6'd8);
      rs_data  = rs_val;
      if (instr_valid && !drv_prev_valid) begin
        branch_cond = branch && (br_taken_left > 0);
        if (branch_cond) br_taken_left--;
      end
      if (instr_valid && pc == stall_pc && stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else begin
        stall = 1'b0;
      end
      drv_prev_valid = instr_valid;
    end
  end

  // Fetch monitor: every accepted read must match the next expected address;
  // a waited read must keep presenting that same address.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && instr_read) begin
        if (fq.size() == 0) begin
          check("fetch_unexpected", instr_address, 32'hFFFFFFFF);
        end else if (instr_waitrequest) begin
          check("fetch_addr_held", instr_address, fq[0]);
        end else begin
          check("fetch_addr", instr_address, fq.pop_front());
        end
      end
    end
  end

  // Execute monitor: checks each executed instruction, its hold under stall and its duration.
  initial begin
    exp_t cur;
    int   run;
    run = 0;
    cur.pc = 32'h0; cur.ins = 32'h0; cur.cycles = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
      end else if (instr_valid) begin
        if (run == 0) begin
          if (eq.size() == 0) begin
            check("exec_unexpected", pc, 32'hFFFFFFFF);
          end else begin
            cur = eq.pop_front();
            check("exec_pc", pc, cur.pc);
            check("exec_instr", instr, cur.ins);
            check("exec_link", link_addr, cur.pc + 32'd8);
          end
        end else begin
          check("hold_pc", pc, cur.pc);
          check("hold_instr", instr, cur.ins);
        end
        run++;
      end else if (run > 0) begin
        check("exec_cycles", run, cur.cycles);
        run = 0;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    fq.delete();
    eq.delete();
    mem.delete();
    wait_left = 0;
    stall_left = 0;
    br_taken_left = 0;
    rs_val = 32'h0;
    repeat (2) @(negedge clk);
  endtask

  // Releases reset (called at a negedge) and runs until the program halts.
  task automatic run_prog(input string name, input int exp_first);
    int  cyc;
    int  first;
    logic done;
    cyc = 0; first = 0; done = 1'b0;
    rst_n = 1'b1;
    while (cyc < 300 && !done) begin
      @(negedge clk);
      cyc++;
      if (first == 0 && instr_valid) first = cyc;
      done = (fq.size() == 0) && (eq.size() == 0) && !active;
    end
    check({name, "_completed"}, done, 1'b1);
    check({name, "_first_exec_cycle"}, first, exp_first);
    repeat (3) @(negedge clk);
    check({name, "_halt_active"}, active, 1'b0);
    check({name, "_halt_read"}, instr_read, 1'b0);
    check({name, "_halt_valid"}, instr_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state.
    do_reset();
    check("rst_pc", pc, V);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_read", instr_read, 1'b0);
    check("rst_active", active, 1'b1);

    // Sequential fetch with zero-wait memory, then jr to 0 at BFC00010 halts after its slot.
    mem[V] = A1; mem[V+4] = A2; mem[V+8] = A3; mem[V+12] = A4; mem[V+16] = JR; mem[V+20] = A5;
    push_f(V); push_f(V+4); push_f(V+8); push_f(V+12); push_f(V+16); push_f(V+20);
    push_e(V, A1, 1); push_e(V+4, A2, 1); push_e(V+8, A3, 1);
    push_e(V+12, A4, 1); push_e(V+16, JR, 1); push_e(V+20, A5, 1);
    run_prog("seq_jr", 2);

    // Three wait states on the first fetch.
    do_reset();
    mem[V] = A1; mem[V+4] = JR; mem[V+8] = A2;
    wait_addr = V; wait_left = 3;
    push_f(V); push_f(V+4); push_f(V+8);
    push_e(V, A1, 1); push_e(V+4, JR, 1); push_e(V+8, A2, 1);
    run_prog("waitreq", 5);

    // beq taken back to itself once, then falls through.
    do_reset();
    mem[V] = BEQ; mem[V+4] = A2; mem[V+8] = JR; mem[V+12] = A3;
    br_taken_left = 1;
    push_f(V); push_f(V+4); push_f(V); push_f(V+4); push_f(V+8); push_f(V+12);
    push_e(V, BEQ, 1); push_e(V+4, A2, 1); push_e(V, BEQ, 1);
    push_e(V+4, A2, 1); push_e(V+8, JR, 1); push_e(V+12, A3, 1);
    run_prog("beq", 2);

    // jal held by a 5-cycle stall, target BFC00100 after the delay slot.
    do_reset();
    mem[V] = JAL; mem[V+4] = A2; mem[V+256] = JR; mem[V+260] = A3;
    stall_pc = V; stall_left = 5;
    push_f(V); push_f(V+4); push_f(V+256); push_f(V+260);
    push_e(V, JAL, 6); push_e(V+4, A2, 1); push_e(V+256, JR, 1); push_e(V+260, A3, 1);
    run_prog("jal_stall", 2);

    // Taken bne in the delay slot of j is ignored.
    do_reset();
    mem[V] = JMP; mem[V+4] = BNE; mem[V+512] = JR; mem[V+516] = A5;
    br_taken_left = 1;
    push_f(V); push_f(V+4); push_f(V+512); push_f(V+516);
    push_e(V, JMP, 1); push_e(V+4, BNE, 1); push_e(V+512, JR, 1); push_e(V+516, A5, 1);
    run_prog("j_bne_slot", 2);

    // Reset pulse mid-stall with a redirect pending; the redirect must be discarded.
    do_reset();
    mem[V] = JMP; mem[V+4] = A2;
    stall_pc = V+4; stall_left = 20;
    push_f(V); push_f(V+4);
    push_e(V, JMP, 1); push_e(V+4, A2, 20);
    rst_n = 1'b1;
    n = 0;
    while (n < 50 && !(instr_valid && pc == V+4)) begin
      @(negedge clk);
      n++;
    end
    check("midstall_reached", n < 50, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pc", pc, V);
    check("midrst_instr", instr, 32'h0);
    check("midrst_valid", instr_valid, 1'b0);
    check("midrst_read", instr_read, 1'b0);
    check("midrst_active", active, 1'b1);
    do_reset();
    mem[V] = A1; mem[V+4] = A2; mem[V+8] = JR; mem[V+12] = A3;
    push_f(V); push_f(V+4); push_f(V+8); push_f(V+12);
    push_e(V, A1, 1); push_e(V+4, A2, 1); push_e(V+8, JR, 1); push_e(V+12, A3, 1);
    run_prog("after_rst", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_cpu_fetch.md
MIPS_CPU_FETCH -- requirements
Module: mips_cpu_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instr_address  output  32  instruction memory byte address.
REQ-005 SHALL have port instr_read  output  1  instruction read request.
REQ-006 SHALL have port instr_waitrequest  input  1  memory not ready; read data invalid while high.
REQ-007 SHALL have port instr_readdata  input  32  instruction word from memory.
REQ-008 SHALL have port instr  output  32  held instruction register; [31:26] drives control opcode, [20:16] drives control branch_type.
REQ-009 SHALL have port instr_valid  output  1  instr is being executed this cycle.
REQ-010 SHALL have port stall  input  1  datapath holds current instruction (e.g. multicycle divide).
REQ-011 SHALL have ports branch, jump  input  1 each  from control decoder.
REQ-012 SHALL have port branch_cond  input  1  ALU condition result; branch taken when branch and branch_cond.
REQ-013 SHALL have port jump_reg  input  1  jr/jalr decoded; target from rs_data.
REQ-014 SHALL have port rs_data  input  32  register rs value.
REQ-015 SHALL have ports pc  output  32  address of instr; link_addr  output  32  pc+8.
REQ-016 SHALL have port active  output  1  CPU running; low once halted.

Function
REQ-017 SHALL implement FSM states FETCH, EXEC, HALTED.
REQ-018 FETCH: instr_read=1, instr_address=pc; when instr_waitrequest=0 at clock edge, capture instr_readdata into instr, go EXEC; else remain FETCH with address held.
REQ-019 EXEC: instr_valid=1, instr_read=0; while stall=1 remain EXEC, instr/pc held.
REQ-020 EXEC leaving (stall=0): if redirect pending, pc<=pending_target and pending cleared; else pc<=pc+4; then FETCH.
REQ-021 Targets, computed from the executing instruction: branch pc+4+(sign-extend(instr[15:0])<<2); jump {pc_plus4[31:28],instr[25:0],2'b00}; jump_reg rs_data; jump_reg has priority over jump, jump over branch.
REQ-022 Taken branch/jump in EXEC (stall=0) with no pending redirect SHALL set pending with its target; delay slot (next sequential instruction) always executes before redirect.
REQ-023 Taken branch/jump inside a delay slot (pending already set) SHALL be ignored; pending redirect wins.
REQ-024 When the applied PC value is 32'h00000000, SHALL enter HALTED instead of FETCH.
REQ-025 HALTED: active=0, instr_read=0, instr_valid=0; stays until reset.
REQ-026 All arithmetic 32-bit modulo 2^32; pc+4 wraps 32'hFFFFFFFC->0 (and then halts per REQ-024).
REQ-027 link_addr SHALL equal pc+8 combinationally, valid whenever instr_valid=1.
REQ-028 Unaligned rs_data targets SHALL be loaded unmodified; no exception generated.

Reset
REQ-029 rst_n low SHALL immediately force state FETCH-pending-release: pc=RESET_VECTOR, instr=0, pending=0, instr_valid=0, instr_read=0, active=1.
REQ-030 First FETCH request SHALL issue on the first rising edge after rst_n deasserts; reset mid-fetch or mid-stall SHALL abandon the access and discard pending redirects.

Verification
REQ-031 Reset release, zero-wait memory -> instr_address=BFC00000, then BFC00004, BFC00008; instr_valid every second cycle.
REQ-032 instr_waitrequest high 3 cycles in FETCH -> instr_address held at BFC00000, instr captured only on 4th edge.
REQ-033 beq taken at BFC00000, imm16=16'hFFFF -> delay slot fetched at BFC00004, next fetch at BFC00000; link_addr=BFC00008 during beq.
REQ-034 jr with rs_data=0 at BFC00010 -> delay slot BFC00014 executes, then active=0, instr_read stays 0.
REQ-035 stall high 5 cycles in EXEC during jal -> pc, instr, instr_valid held; target {B,26'h...,00} applied after delay slot once.
REQ-036 Taken bne in delay slot of j -> j target used, bne ignored; rst_n pulse mid-stall -> pc=BFC00000, active=1.
